// File: rtl/conv_pkg.sv
// Shared definitions for the 4x4-tile / 3x3-filter convolution sequencer:
// state encoding, tile geometry and flat-bus index helpers.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        MAC  = 3'd3,
        DONE = 3'd4
    } conv_state_t;

    localparam int TILE_N  = 4;
    localparam int FILT_N  = 3;
    localparam int OUT_N   = 2;
    localparam int TAPS    = FILT_N * FILT_N;
    localparam int WINDOWS = OUT_N * OUT_N;

    // Element a(r,c) of the data tile lives at index 4r+c of data_flat.
    function automatic int data_idx(input int r, input int c);
        return r * TILE_N + c;
    endfunction

    // Element b(i,j) of the filter lives at index 3i+j of filt_flat.
    function automatic int filt_idx(input int i, input int j);
        return i * FILT_N + j;
    endfunction

    // Result y(p,q) lives at index 2p+q of result_flat.
    function automatic int res_idx(input int p, input int q);
        return p * OUT_N + q;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Serial signed multiply-accumulate for one convolution window.
// sum is the value the accumulator takes on the next enabled edge, so the
// sequencer can capture a window's final sum in the same cycle as its last tap.
module conv_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [ACC_W-1:0] sum
);

    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           base;
    logic [ACC_W-1:0]           acc;

    assign prod     = $signed(op_a) * $signed(op_b);
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign base     = clear ? '0 : acc;
    assign sum      = base + prod_ext;

    // Accumulator: restarts from zero on the first tap of each window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution sequencer: loads the operand memory, then walks the four 3x3
// windows of the 4x4 tile with nine serial MACs each, filling a 2x2 result
// buffer.
// Optional build macro CONV_SEQ_RELU_EN: clamp negative results to zero at
// write time (timing unchanged).
//
// Handshake: start is a single-cycle request honoured only in IDLE (never
// queued). mem_activate is a one-cycle strobe in LOAD; the memory answers
// with mem_done, which is only looked at in WAIT and may arrive any number of
// cycles later. done pulses for one cycle when result_flat holds a complete
// run, and result_valid stays high until the next accepted start.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  mem_activate,
    input  logic                  mem_done,
    input  logic [16*DATA_W-1:0]  data_flat,
    input  logic [9*DATA_W-1:0]   filt_flat,
    output logic                  busy,
    output logic                  done,
    output logic [4*ACC_W-1:0]    result_flat,
    output logic                  result_valid
);

    localparam logic [3:0] K_LAST = 4'(TAPS - 1);
    localparam logic [1:0] W_LAST = 2'(WINDOWS - 1);

    conv_state_t       state;
    logic [3:0]        k;
    logic [1:0]        w;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ACC_W-1:0]  mac_sum;
    logic [ACC_W-1:0]  store_val;
    int                tap_i;
    int                tap_j;
    int                win_p;
    int                win_q;

    assign busy = (state != IDLE);

    // Operand muxes: pick a(p+i, q+j) and b(i,j) for the current tap/window.
    always_comb begin
        tap_i = int'(k) / FILT_N;
        tap_j = int'(k) % FILT_N;
        win_p = int'(w) / OUT_N;
        win_q = int'(w) % OUT_N;
        op_a  = data_flat[data_idx(win_p + tap_i, win_q + tap_j) * DATA_W +: DATA_W];
        op_b  = filt_flat[filt_idx(tap_i, tap_j) * DATA_W +: DATA_W];
    end

    // Value written into the result buffer at the end of a window.
    always_comb begin
`ifdef CONV_SEQ_RELU_EN
        store_val = mac_sum[ACC_W-1] ? '0 : mac_sum;
`else
        store_val = mac_sum;
`endif
    end

    conv_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (k == 4'd0),
        .enable (state == MAC),
        .op_a   (op_a),
        .op_b   (op_b),
        .sum    (mac_sum)
    );

    // Control FSM with tap/window counters, registered strobes and result buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= 4'd0;
            w            <= 2'd0;
            mem_activate <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            result_flat  <= '0;
        end else begin
            mem_activate <= 1'b0;
            done         <= 1'b0;
            if (abort && state != IDLE) begin
                // Cancel wins over everything; partial results are left as-is.
                state        <= IDLE;
                k            <= 4'd0;
                w            <= 2'd0;
                result_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state        <= LOAD;
                            mem_activate <= 1'b1;
                            result_valid <= 1'b0;
                            k            <= 4'd0;
                            w            <= 2'd0;
                        end
                    end
                    LOAD: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (mem_done) begin
                            state <= MAC;
                        end
                    end
                    MAC: begin
                        if (k == K_LAST) begin
                            result_flat[int'(w) * ACC_W +: ACC_W] <= store_val;
                            k <= 4'd0;
                            w <= w + 2'd1;
                            if (w == W_LAST) begin
                                state        <= DONE;
                                done         <= 1'b1;
                                result_valid <= 1'b1;
                            end
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: drives tiles through a behavioural memory
// handshake and checks timing and results against a direct convolution model.
module tb_conv_sequencer;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic                 mem_activate;
    logic                 mem_done;
    logic [16*DATA_W-1:0] data_flat;
    logic [9*DATA_W-1:0]  filt_flat;
    logic                 busy;
    logic                 done;
    logic [4*ACC_W-1:0]   result_flat;
    logic                 result_valid;

    logic [DATA_W-1:0] dmem [16];
    logic [DATA_W-1:0] fmem [9];

    logic [ACC_W-1:0] exp_q [$];
    int n_cmp;
    int n_err;

    int r_done_cyc;
    int r_act_cnt;
    int r_done_cnt;
    int r_rv_at_done;
    int r_busy_after;

    conv_sequencer #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mem_activate (mem_activate),
        .mem_done     (mem_done),
        .data_flat    (data_flat),
        .filt_flat    (filt_flat),
        .busy         (busy),
        .done         (done),
        .result_flat  (result_flat),
        .result_valid (result_valid)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int n = 0; n < 16; n++) data_flat[n*DATA_W +: DATA_W] = dmem[n];
        for (int n = 0; n < 9; n++)  filt_flat[n*DATA_W +: DATA_W] = fmem[n];
    end

    // Reference model: direct 2-D valid convolution of the current memory
    function automatic int sx(input logic [DATA_W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_push();
        for (int p = 0; p < 2; p++) begin
            for (int q = 0; q < 2; q++) begin
                int s;
                logic [ACC_W-1:0] v;
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += sx(dmem[(p+i)*4 + (q+j)]) * sx(fmem[i*3 + j]);
`ifdef CONV_SEQ_RELU_EN
                if (s < 0) s = 0;
`endif
                v = s[ACC_W-1:0];
                exp_q.push_back(v);
            end
        end
    endtask

    // Driver: one tile request with memory acknowledge after 'extra' waits
    task automatic run_tile(input int extra, input int abort_at, input bit poke_start);
        int md_at;
        md_at        = -1;
        r_done_cyc   = -1;
        r_act_cnt    = 0;
        r_done_cnt   = 0;
        r_rv_at_done = 0;
        r_busy_after = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (mem_activate) begin
                r_act_cnt++;
                if (md_at < 0) md_at = cyc + 1 + extra;
            end
            if (cyc == abort_at + 1) r_busy_after = int'(busy);
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc   = cyc;
                    r_rv_at_done = int'(result_valid);
                end
                if (abort_at < 0) break;
            end
            mem_done = (cyc == md_at);
            abort    = (cyc == abort_at);
            start    = poke_start && (cyc == 4 || cyc == 12);
            @(negedge clk);
        end
        mem_done = 1'b0;
        abort    = 1'b0;
        start    = 1'b0;
    endtask

    task automatic fill(input logic [DATA_W-1:0] dv, input logic [DATA_W-1:0] fv);
        for (int n = 0; n < 16; n++) dmem[n] = dv;
        for (int n = 0; n < 9; n++)  fmem[n] = fv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_done = 1'b0;
        fill('0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (mem_activate !== 1'b0) begin n_err++; $display("FAIL reset_act: got %b want 0", mem_activate); end
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b want 0", result_valid); end
        n_cmp++; if (result_flat !== '0) begin n_err++; $display("FAIL reset_res: got %h want 0", result_flat); end
    endtask

    task automatic test_ones();
        logic [ACC_W-1:0] e;
        fill(8'h01, 8'h01);
        model_push();
        run_tile(0, -1, 1'b0);
        n_cmp++; if (r_done_cyc !== 38) begin n_err++; $display("FAIL ones_latency: got %0d want 38", r_done_cyc); end
        n_cmp++; if (r_rv_at_done !== 1) begin n_err++; $display("FAIL ones_rv: got %0d want 1", r_rv_at_done); end
        n_cmp++; if (r_act_cnt !== 1) begin n_err++; $display("FAIL ones_act: got %0d want 1", r_act_cnt); end
        for (int n = 0; n < 4; n++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (result_flat[n*ACC_W +: ACC_W] !== e) begin
                n_err++; $display("FAIL ones_y%0d: got %h want %h", n, result_flat[n*ACC_W +: ACC_W], e);
            end
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ones_after: done %b busy %b want 0 0", done, busy); end
        n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("FAIL ones_rv_hold: got %b want 1", result_valid); end
    endtask

    // Runs the currently loaded tile and compares all four results
    task automatic test_pattern(input string name, input int extra);
        logic [ACC_W-1:0] e;
        model_push();
        run_tile(extra, -1, 1'b0);
        n_cmp++;
        if (r_done_cyc !== 38 + extra) begin
            n_err++; $display("FAIL %s_latency: got %0d want %0d", name, r_done_cyc, 38 + extra);
        end
        for (int n = 0; n < 4; n++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (result_flat[n*ACC_W +: ACC_W] !== e) begin
                n_err++; $display("FAIL %s_y%0d: got %h want %h", name, n, result_flat[n*ACC_W +: ACC_W], e);
            end
        end
    endtask

    task automatic test_identity();
        for (int n = 0; n < 16; n++) dmem[n] = 8'(n + 1);
        for (int n = 0; n < 9; n++)  fmem[n] = 8'h00;
        fmem[4] = 8'h01;
        test_pattern("identity", 0);
    endtask

    task automatic test_min();
        fill(8'h80, 8'h80);
        test_pattern("min", 1);
    endtask

    task automatic test_neg();
        fill(8'h01, 8'hFF);
        test_pattern("neg", 2);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int n = 0; n < 16; n++) dmem[n] = 8'($urandom_range(0, 255));
            for (int n = 0; n < 9; n++)  fmem[n] = 8'($urandom_range(0, 255));
            test_pattern("random", int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_abort();
        fill(8'h01, 8'h01);
        run_tile(5, 27, 1'b1);
        n_cmp++; if (r_act_cnt !== 1) begin n_err++; $display("FAIL abort_act: got %0d want 1", r_act_cnt); end
        n_cmp++; if (r_done_cnt !== 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", r_done_cnt); end
        n_cmp++; if (r_busy_after !== 0) begin n_err++; $display("FAIL abort_busy: got %0d want 0", r_busy_after); end
        n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL abort_rv: got %b want 0", result_valid); end
    endtask

    task automatic test_reset_mid();
        fill(8'h01, 8'h01);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); mem_done = 1'b1;
        @(negedge clk); mem_done = 1'b0;
        repeat (13) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_running: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (result_flat !== '0) begin n_err++; $display("FAIL midrst_res: got %h want 0", result_flat); end
        n_cmp++; if (done !== 1'b0 || result_valid !== 1'b0 || mem_activate !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags: got %b%b%b want 000", done, result_valid, mem_activate);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_ones();
    endtask

    // Sequence of scenarios and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ones();
        test_identity();
        test_min();
        test_neg();
        test_random();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Controller for the 4x4 data / 3x3 filter operand memory.
- On start, pulses the memory's load strobe, waits for its acknowledge, then walks the four valid 3x3 windows of the 4x4 tile. For each window it performs 9 serial signed multiply-accumulates and writes one result to a 2x2 output buffer.
- Sits between the top-level control FSM and the operand memory, and owns the convolution datapath schedule.

Parameters:
- DATA_W, 8, operand width in bits; signed two's complement.
- ACC_W, 20, accumulator and result width in bits; must be at least 2*DATA_W+4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run one tile.
- abort  in  1  synchronous cancel of the current run.
- mem_activate  out  1  load strobe to the operand memory.
- mem_done  in  1  memory acknowledge; high for the cycle after the memory samples mem_activate.
- data_flat  in  16*DATA_W  memory data outputs; element a(r,c) at index 4r+c (r,c = 0..3), LSB-first.
- filt_flat  in  9*DATA_W  memory filter outputs; element b(i,j) at index 3i+j (i,j = 0..2).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a run completes.
- result_flat  out  4*ACC_W  results y(p,q) at index 2p+q (p,q = 0..1).
- result_valid  out  1  high while result_flat holds a complete run.

Behaviour:
- Reset: state IDLE; all counters 0; mem_activate, busy, done and result_valid 0; result_flat 0.
- States:
  - IDLE: start=1 -> LOAD. Clears result_valid.
  - LOAD: mem_activate=1 for exactly this one cycle -> WAIT.
  - WAIT: mem_done=1 -> MAC; otherwise remain in WAIT. There is no timeout.
  - MAC: tap counter k runs 0..8, with i=k/3, j=k%3. Window counter w runs 0..3, with p=w/2, q=w%2.
    - Each cycle: acc <= (k==0 ? 0 : acc) + a(p+i, q+j)*b(i,j).
    - Product is full 2*DATA_W signed, sign-extended to ACC_W.
    - At k==8: result[w] <= final sum; k wraps to 0; w increments.
    - At w==3 and k==8 -> DONE.
  - DONE: done=1 and result_valid is set -> IDLE.
- Latency: let E0 be the edge that samples start.
  - LOAD is the cycle after E0; WAIT is the cycle after E1.
  - MAC occupies 36 cycles, E2..E37.
  - done is high in the cycle after E38.
  - With an immediate mem_done this is 38 cycles from start; each extra WAIT cycle adds one.
- Operands: data_flat and filt_flat are sampled live each MAC cycle. The memory must hold its contents throughout MAC.
- start while busy: ignored, with no queueing.
- start in the same cycle DONE returns to IDLE: not seen; the next start must come in IDLE.
- abort (any non-IDLE state): next state is IDLE.
  - No done pulse; result_valid stays 0.
  - result_flat keeps any partially written windows, which are undefined for use.
  - abort has priority over mem_done and window completion.
- mem_done outside WAIT: ignored.
- Async reset mid-run: immediate return to reset values.
- Arithmetic: no saturation. Nine products of magnitude at most 2^14 always fit in ACC_W=20 signed.

Optional Feature:
- Macro CONV_SEQ_RELU_EN.
- When defined: each result is clamped at write time; a negative final sum is stored as 0.
- When undefined: the signed sum is stored unchanged.
- Timing is identical in both builds.

Decomposition:
- Package conv_pkg:
  - state enum (IDLE, LOAD, WAIT, MAC, DONE);
  - constants TILE_N=4, FILT_N=3, OUT_N=2, TAPS=9, WINDOWS=4;
  - helper functions for flat-index computation.
- Sub-module conv_mac_unit:
  - signed multiply plus accumulate register;
  - inputs clear, enable and two operands;
  - ACC_W output.
- The sequencer contains the FSM, the counters, the operand muxes and the result buffer.

Test Plan:
- All data = 1, all filter = 1; start with mem_done one cycle after LOAD -> done 38 cycles after start; every y = 9; result_valid = 1.
- Data a(r,c) = 4r+c+1, filter b(1,1) = 1 and all other taps 0 -> y = {6, 7, 10, 11}.
- All data = 0x80, all filter = 0x80 -> every y = 147456 (0x24000).
- All data = 1, all filter = 0xFF -> y = 0xFFFF7 (-9) without CONV_SEQ_RELU_EN; y = 0 with it.
- Hold mem_done low 5 cycles, pulse start twice while busy, then abort at MAC cycle 20 -> single LOAD pulse; return to IDLE; no done; result_valid = 0.
- Deassert rst_n mid-MAC, then release and run test 1 -> all outputs reset immediately; the fresh run yields y = 9.
